// File: rtl/bus_arbiter_if.sv
// Signal bundle for bus_arbiter: two master request channels, the shared
// slave channel and the one-hot grant vector.
interface bus_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] m0_address;
  logic [ADDR_W-1:0] m1_address;
  logic [DATA_W-1:0] m0_data_out;
  logic [DATA_W-1:0] m1_data_out;
  logic              m0_read;
  logic              m1_read;
  logic              m0_write;
  logic              m1_write;
  logic [DATA_W-1:0] m0_data_in;
  logic [DATA_W-1:0] m1_data_in;
  logic              m0_ready;
  logic              m1_ready;
  logic              m0_err;
  logic              m1_err;
  logic [ADDR_W-1:0] s_address;
  logic [DATA_W-1:0] s_data_out;
  logic              s_read;
  logic              s_write;
  logic [DATA_W-1:0] s_data_in;
  logic              s_ready;
  logic [1:0]        grant;

  // Arbiter view: answers both masters and drives the shared slave bus.
  modport slave (
    input  m0_address, m1_address, m0_data_out, m1_data_out,
    input  m0_read, m1_read, m0_write, m1_write,
    input  s_data_in, s_ready,
    output m0_data_in, m1_data_in, m0_ready, m1_ready, m0_err, m1_err,
    output s_address, s_data_out, s_read, s_write, grant
  );

  // Environment view: the two bus masters plus the memory/peripheral slave.
  modport master (
    output m0_address, m1_address, m0_data_out, m1_data_out,
    output m0_read, m1_read, m0_write, m1_write,
    output s_data_in, s_ready,
    input  m0_data_in, m1_data_in, m0_ready, m1_ready, m0_err, m1_err,
    input  s_address, s_data_out, s_read, s_write, grant
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for the shared external bus, with a bounded
// wait on the slave: transactions not completed within TIMEOUT cycles abort.
module bus_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic         clk,
  input  logic         reset,
  bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic              wr_q, wr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        grant_q, grant_d;
  logic              s_read_q, s_read_d;
  logic              s_write_q, s_write_d;
  logic              m0_ready_q, m0_ready_d;
  logic              m1_ready_q, m1_ready_d;
  logic              m0_err_q, m0_err_d;
  logic              m1_err_q, m1_err_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;

  logic              req0, req1, pick, finish, abort;
  logic [DATA_W-1:0] ret_data;

  // On a tie the master that did not own the bus last goes next.
  function automatic logic pick_owner(input logic r0, input logic r1, input logic last);
    if (r0 && r1) return ~last;
    return r1;
  endfunction

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    wr_d         = wr_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    grant_d      = grant_q;
    s_read_d     = s_read_q;
    s_write_d    = s_write_q;
    m0_ready_d   = 1'b0;
    m1_ready_d   = 1'b0;
    m0_err_d     = 1'b0;
    m1_err_d     = 1'b0;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;

    req0     = bus.m0_read | bus.m0_write;
    req1     = bus.m1_read | bus.m1_write;
    pick     = pick_owner(req0, req1, last_owner_q);
    // s_ready beats a timeout landing on the same edge.
    finish   = bus.s_ready;
    abort    = !bus.s_ready && (cnt_q == CNT_LAST);
    ret_data = bus.s_ready ? bus.s_data_in : {DATA_W{1'b1}};

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          owner_d   = pick;
          addr_d    = pick ? bus.m1_address  : bus.m0_address;
          wdata_d   = pick ? bus.m1_data_out : bus.m0_data_out;
          // A simultaneous read+write request is treated as a write.
          wr_d      = pick ? bus.m1_write    : bus.m0_write;
          cnt_d     = '0;
          grant_d   = pick ? 2'b10 : 2'b01;
          s_write_d = wr_d;
          s_read_d  = ~wr_d;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (finish || abort) begin
          s_read_d  = 1'b0;
          s_write_d = 1'b0;
          state_d   = DONE;
          if (owner_q) begin
            m1_ready_d = 1'b1;
            m1_err_d   = abort;
            if (!wr_q) m1_rdata_d = ret_data;
          end else begin
            m0_ready_d = 1'b1;
            m0_err_d   = abort;
            if (!wr_q) m0_rdata_d = ret_data;
          end
        end
      end
      DONE: begin
        grant_d      = 2'b00;
        last_owner_d = owner_q;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      wr_q         <= 1'b0;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      grant_q      <= 2'b00;
      s_read_q     <= 1'b0;
      s_write_q    <= 1'b0;
      m0_ready_q   <= 1'b0;
      m1_ready_q   <= 1'b0;
      m0_err_q     <= 1'b0;
      m1_err_q     <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      wr_q         <= wr_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      grant_q      <= grant_d;
      s_read_q     <= s_read_d;
      s_write_q    <= s_write_d;
      m0_ready_q   <= m0_ready_d;
      m1_ready_q   <= m1_ready_d;
      m0_err_q     <= m0_err_d;
      m1_err_q     <= m1_err_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.s_address  = addr_q;
  assign bus.s_data_out = wdata_q;
  assign bus.s_read     = s_read_q;
  assign bus.s_write    = s_write_q;
  assign bus.m0_ready   = m0_ready_q;
  assign bus.m1_ready   = m1_ready_q;
  assign bus.m0_err     = m0_err_q;
  assign bus.m1_err     = m1_err_q;
  assign bus.m0_data_in = m0_rdata_q;
  assign bus.m1_data_in = m1_rdata_q;

endmodule
